// File: rtl/dmem_arbiter_if.sv
// Bundle of the CPU (C), debug (D) and memory (M) signals around the data-memory arbiter.
// Handshake: a requester raises *_req_i with stable we/addr/wdata and holds it until its one-cycle *_ack_o.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              start_i;
  logic              c_req_i;
  logic              c_we_i;
  logic [ADDR_W-1:0] c_addr_i;
  logic [DATA_W-1:0] c_wdata_i;
  logic [DATA_W-1:0] c_rdata_o;
  logic              c_ack_o;
  logic              stall_o;
  logic              d_req_i;
  logic              d_we_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic [DATA_W-1:0] d_rdata_o;
  logic              d_ack_o;
  logic [ADDR_W-1:0] m_addr_o;
  logic [DATA_W-1:0] m_wdata_o;
  logic              m_read_o;
  logic              m_write_o;
  logic [DATA_W-1:0] m_rdata_i;

  modport slave (
    input  start_i, c_req_i, c_we_i, c_addr_i, c_wdata_i,
           d_req_i, d_we_i, d_addr_i, d_wdata_i, m_rdata_i,
    output c_rdata_o, c_ack_o, stall_o, d_rdata_o, d_ack_o,
           m_addr_o, m_wdata_o, m_read_o, m_write_o
  );

  modport master (
    output start_i, c_req_i, c_we_i, c_addr_i, c_wdata_i,
           d_req_i, d_we_i, d_addr_i, d_wdata_i, m_rdata_i,
    input  c_rdata_o, c_ack_o, stall_o, d_rdata_o, d_ack_o,
           m_addr_o, m_wdata_o, m_read_o, m_write_o
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port (CPU / debug) data-memory arbiter: one access in flight, fixed strobe latency, CPU stall.
// DMEM_ARB_CPU_PRIO_EN selects fixed CPU priority instead of round-robin.
module dmem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  output logic [1:0]   dbg_state_o,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              gnt_q, gnt_d;        // 1 = debug port owns the access
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] c_rdata_q, c_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              pick_d;
`ifndef DMEM_ARB_CPU_PRIO_EN
  logic              last_d_q, last_d_d;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      gnt_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
`ifndef DMEM_ARB_CPU_PRIO_EN
      last_d_q  <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      c_rdata_q <= c_rdata_d;
      d_rdata_q <= d_rdata_d;
`ifndef DMEM_ARB_CPU_PRIO_EN
      last_d_q  <= last_d_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    c_rdata_d = c_rdata_q;
    d_rdata_d = d_rdata_q;
`ifdef DMEM_ARB_CPU_PRIO_EN
    pick_d    = bus.d_req_i & ~bus.c_req_i;
`else
    last_d_d  = last_d_q;
    // On a tie the port that did not own the previous access wins.
    pick_d    = bus.d_req_i & (~bus.c_req_i | ~last_d_q);
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start_i && (bus.c_req_i || bus.d_req_i)) begin
          gnt_d   = pick_d;
          we_d    = pick_d ? bus.d_we_i    : bus.c_we_i;
          addr_d  = pick_d ? bus.d_addr_i  : bus.c_addr_i;
          wdata_d = pick_d ? bus.d_wdata_i : bus.c_wdata_i;
          cnt_d   = CNT_INIT;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) begin
            if (gnt_q) d_rdata_d = bus.m_rdata_i;
            else       c_rdata_d = bus.m_rdata_i;
          end
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
`ifndef DMEM_ARB_CPU_PRIO_EN
        last_d_d = gnt_q;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.m_addr_o  = addr_q;
  assign bus.m_wdata_o = wdata_q;
  assign bus.m_read_o  = (state_q == S_ACCESS) & ~we_q;
  assign bus.m_write_o = (state_q == S_ACCESS) &  we_q;
  assign bus.c_ack_o   = (state_q == S_DONE) & ~gnt_q;
  assign bus.d_ack_o   = (state_q == S_DONE) &  gnt_q;
  assign bus.c_rdata_o = c_rdata_q;
  assign bus.d_rdata_o = d_rdata_q;
  assign bus.stall_o   = bus.c_req_i & ~bus.c_ack_o;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: latency-2 instance for the main scenarios, latency-1 instance for back-to-back reads.
module tb_dmem_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = 2;
  localparam int LAT1 = 1;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] st, st1;
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] gnt_exp_q[$];
  int rcnt = 0;
  int rcnt1 = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT)) u_dut (
    .clk_i(clk), .rst_i(rst_n), .dbg_state_o(st), .bus(bus)
  );
  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT1)) u_dut1 (
    .clk_i(clk), .rst_i(rst_n), .dbg_state_o(st1), .bus(bus1)
  );

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // Memory models: data is only valid on the last strobe cycle, garbage before it.
  always @(posedge clk) rcnt  <= bus.m_read_o  ? rcnt + 1  : 0;
  always @(posedge clk) rcnt1 <= bus1.m_read_o ? rcnt1 + 1 : 0;
  assign bus.m_rdata_i  = (bus.m_read_o  && rcnt  == LAT - 1)  ? mem_val(bus.m_addr_o)  : 32'hBAD0BAD0;
  assign bus1.m_rdata_i = (bus1.m_read_o && rcnt1 == LAT1 - 1) ? mem_val(bus1.m_addr_o) : 32'hBAD0BAD0;

  task automatic idle_inputs();
    bus.start_i = 1'b1;  bus.c_req_i = 1'b0;  bus.c_we_i = 1'b0;  bus.c_addr_i = '0;  bus.c_wdata_i = '0;
    bus.d_req_i = 1'b0;  bus.d_we_i = 1'b0;   bus.d_addr_i = '0;  bus.d_wdata_i = '0;
    bus1.start_i = 1'b1; bus1.c_req_i = 1'b0; bus1.c_we_i = 1'b0; bus1.c_addr_i = '0; bus1.c_wdata_i = '0;
    bus1.d_req_i = 1'b0; bus1.d_we_i = 1'b0;  bus1.d_addr_i = '0; bus1.d_wdata_i = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.c_req_i = 1'b1;
    #1;
    checks++; if (bus.m_read_o !== 1'b0 || bus.m_write_o !== 1'b0) begin errors++; $display("FAIL reset_strobes: got %b%b expected 00", bus.m_read_o, bus.m_write_o); end
    checks++; if (bus.c_ack_o !== 1'b0 || bus.d_ack_o !== 1'b0) begin errors++; $display("FAIL reset_acks: got %b%b expected 00", bus.c_ack_o, bus.d_ack_o); end
    checks++; if (bus.c_rdata_o !== '0 || bus.d_rdata_o !== '0) begin errors++; $display("FAIL reset_rdata: got %h/%h expected 0", bus.c_rdata_o, bus.d_rdata_o); end
    checks++; if (bus.m_addr_o !== '0 || bus.m_wdata_o !== '0) begin errors++; $display("FAIL reset_maddr: got %h/%h expected 0", bus.m_addr_o, bus.m_wdata_o); end
    checks++; if (st !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", st); end
    checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL reset_stall_comb: got %b expected 1", bus.stall_o); end
    bus.c_req_i = 1'b0;
    #1;
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall_idle: got %b expected 0", bus.stall_o); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++; if (st !== 2'd0) begin errors++; $display("FAIL post_reset_state: got %0d expected 0", st); end
  endtask

  task automatic test_cpu_read();
    logic [DW-1:0] exp;
    @(negedge clk);
    bus.c_req_i = 1'b1; bus.c_we_i = 1'b0; bus.c_addr_i = 32'h10;
    exp_q.push_back(mem_val(32'h10));
    #1;
    checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL read_stall_c0: got %b expected 1", bus.stall_o); end
    for (int cyc = 1; cyc <= LAT; cyc++) begin
      @(negedge clk);
      checks++; if (bus.m_read_o !== 1'b1 || bus.m_write_o !== 1'b0) begin errors++; $display("FAIL read_strobe c%0d: got r%b w%b expected r1 w0", cyc, bus.m_read_o, bus.m_write_o); end
      checks++; if (bus.m_addr_o !== 32'h10) begin errors++; $display("FAIL read_addr c%0d: got %h expected 00000010", cyc, bus.m_addr_o); end
      checks++; if (bus.stall_o !== 1'b1 || bus.c_ack_o !== 1'b0) begin errors++; $display("FAIL read_stall c%0d: got stall %b ack %b expected 1 0", cyc, bus.stall_o, bus.c_ack_o); end
    end
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++; if (bus.c_ack_o !== 1'b1) begin errors++; $display("FAIL read_ack: got %b expected 1", bus.c_ack_o); end
    checks++; if (bus.c_rdata_o !== exp) begin errors++; $display("FAIL read_data: got %h expected %h", bus.c_rdata_o, exp); end
    checks++; if (bus.stall_o !== 1'b0 || bus.m_read_o !== 1'b0) begin errors++; $display("FAIL read_done: got stall %b rd %b expected 0 0", bus.stall_o, bus.m_read_o); end
    bus.c_req_i = 1'b0;
    @(negedge clk);
    checks++; if (bus.c_ack_o !== 1'b0) begin errors++; $display("FAIL read_ack_pulse: got %b expected 0", bus.c_ack_o); end
    checks++; if (bus.c_rdata_o !== exp) begin errors++; $display("FAIL read_data_hold: got %h expected %h", bus.c_rdata_o, exp); end
  endtask

  task automatic test_cpu_write();
    int wcnt = 0;
    int rdcnt = 0;
    int acks = 0;
    logic [DW-1:0] exp;
    @(negedge clk);
    bus.c_req_i = 1'b1; bus.c_we_i = 1'b1; bus.c_addr_i = 32'h20; bus.c_wdata_i = 32'h12345678;
    exp_q.push_back(mem_val(32'h10));
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      if (bus.m_write_o) begin
        wcnt++;
        checks++; if (bus.m_addr_o !== 32'h20 || bus.m_wdata_o !== 32'h12345678) begin errors++; $display("FAIL write_bus c%0d: got %h/%h expected 00000020/12345678", cyc, bus.m_addr_o, bus.m_wdata_o); end
      end
      if (bus.m_read_o) rdcnt++;
      if (bus.c_ack_o) begin
        acks++;
        exp = exp_q.pop_front();
        checks++; if (bus.c_rdata_o !== exp) begin errors++; $display("FAIL write_rdata_kept: got %h expected %h", bus.c_rdata_o, exp); end
        bus.c_req_i = 1'b0; bus.c_we_i = 1'b0;
      end
    end
    checks++; if (wcnt != LAT) begin errors++; $display("FAIL write_strobe_cycles: got %0d expected %0d", wcnt, LAT); end
    checks++; if (rdcnt != 0) begin errors++; $display("FAIL write_no_read: got %0d expected 0", rdcnt); end
    checks++; if (acks != 1) begin errors++; $display("FAIL write_ack_count: got %0d expected 1", acks); end
  endtask

  task automatic test_round_robin();
    int nacks = 0;
    int last_cyc = 0;
    logic [DW-1:0] eg, ed, got;
    @(negedge clk); rst_n = 1'b0;
    bus.c_req_i = 1'b1; bus.c_we_i = 1'b0; bus.c_addr_i = 32'h100;
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_addr_i = 32'h200;
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_CPU_PRIO_EN
      gnt_exp_q.push_back(32'd0); exp_q.push_back(mem_val(32'h100));
`else
      gnt_exp_q.push_back(DW'(i % 2)); exp_q.push_back(mem_val((i % 2) ? 32'h200 : 32'h100));
`endif
    end
    @(negedge clk); rst_n = 1'b1;
    for (int cyc = 1; cyc <= 40 && nacks < 4; cyc++) begin
      @(negedge clk);
      checks++; if (bus.m_read_o && bus.m_write_o) begin errors++; $display("FAIL rr_two_strobes c%0d: got both high expected one", cyc); end
      if (bus.c_ack_o || bus.d_ack_o) begin
        eg = gnt_exp_q.pop_front();
        ed = exp_q.pop_front();
        got = bus.d_ack_o ? bus.d_rdata_o : bus.c_rdata_o;
        checks++; if ({bus.c_ack_o, bus.d_ack_o} !== {~eg[0], eg[0]}) begin errors++; $display("FAIL rr_grant #%0d: got c%b d%b expected port %0d", nacks, bus.c_ack_o, bus.d_ack_o, eg); end
        checks++; if (got !== ed) begin errors++; $display("FAIL rr_data #%0d: got %h expected %h", nacks, got, ed); end
        if (nacks == 0) begin
          checks++; if (cyc != LAT + 1) begin errors++; $display("FAIL rr_first_ack: got cycle %0d expected %0d", cyc, LAT + 1); end
        end else begin
          checks++; if (cyc - last_cyc != LAT + 2) begin errors++; $display("FAIL rr_spacing #%0d: got %0d expected %0d", nacks, cyc - last_cyc, LAT + 2); end
        end
        last_cyc = cyc;
        nacks++;
      end
    end
    checks++; if (nacks != 4) begin errors++; $display("FAIL rr_timeout: got %0d acks expected 4", nacks); end
    bus.c_req_i = 1'b0; bus.d_req_i = 1'b0;
    gnt_exp_q.delete(); exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_start_gate();
    bit seen_c = 1'b0;
    bit seen_d = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    bus.start_i = 1'b0;
    bus.c_req_i = 1'b1; bus.c_we_i = 1'b0; bus.c_addr_i = 32'h140;
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_addr_i = 32'h240;
    @(negedge clk); rst_n = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      checks++; if ((bus.m_read_o | bus.m_write_o | bus.c_ack_o | bus.d_ack_o) !== 1'b0 || bus.stall_o !== 1'b1) begin errors++; $display("FAIL gate_blocked c%0d: got rd%b wr%b ca%b da%b stall%b expected 0 0 0 0 1", cyc, bus.m_read_o, bus.m_write_o, bus.c_ack_o, bus.d_ack_o, bus.stall_o); end
    end
    bus.start_i = 1'b1;
    exp_q.push_back(mem_val(32'h140));
    exp_q.push_back(mem_val(32'h240));
    for (int cyc = 1; cyc <= 30 && !seen_d; cyc++) begin
      @(negedge clk);
      if (bus.d_ack_o && !seen_c) begin
        checks++; errors++; $display("FAIL gate_first_grant: got D expected C");
        seen_c = 1'b1; void'(exp_q.pop_front());
      end
      if (bus.c_ack_o && !seen_c) begin
        seen_c = 1'b1;
        checks++; if (bus.c_rdata_o !== exp_q[0]) begin errors++; $display("FAIL gate_c_data: got %h expected %h", bus.c_rdata_o, exp_q[0]); end
        void'(exp_q.pop_front());
        bus.c_req_i = 1'b0;
      end else if (bus.d_ack_o) begin
        seen_d = 1'b1;
        checks++; if (bus.d_rdata_o !== exp_q[0]) begin errors++; $display("FAIL gate_d_data: got %h expected %h", bus.d_rdata_o, exp_q[0]); end
        void'(exp_q.pop_front());
        bus.d_req_i = 1'b0;
      end
    end
    checks++; if (!(seen_c && seen_d)) begin errors++; $display("FAIL gate_timeout: got c%b d%b expected both acked", seen_c, seen_d); end
    bus.c_req_i = 1'b0; bus.d_req_i = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int order = 0;
    @(negedge clk);
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_addr_i = 32'h300;
    @(negedge clk);
    checks++; if (bus.m_read_o !== 1'b1 || bus.m_addr_o !== 32'h300) begin errors++; $display("FAIL rmid_c1: got rd%b addr %h expected 1 00000300", bus.m_read_o, bus.m_addr_o); end
    @(negedge clk);
    checks++; if (bus.m_read_o !== 1'b1) begin errors++; $display("FAIL rmid_c2: got %b expected 1", bus.m_read_o); end
    #2; rst_n = 1'b0;
    bus.c_req_i = 1'b1; bus.c_we_i = 1'b0; bus.c_addr_i = 32'h400;
    #1;
    checks++; if (bus.d_ack_o !== 1'b0 || bus.m_read_o !== 1'b0 || st !== 2'd0) begin errors++; $display("FAIL rmid_clear: got ack%b rd%b st%0d expected 0 0 0", bus.d_ack_o, bus.m_read_o, st); end
    exp_q.push_back(mem_val(32'h400));
    exp_q.push_back(mem_val(32'h300));
    @(negedge clk); rst_n = 1'b1;
    for (int cyc = 1; cyc <= 30 && order < 2; cyc++) begin
      @(negedge clk);
      if (bus.c_ack_o || bus.d_ack_o) begin
        checks++; if (bus.c_ack_o !== (order == 0)) begin errors++; $display("FAIL rmid_order #%0d: got c%b d%b expected %s", order, bus.c_ack_o, bus.d_ack_o, order == 0 ? "C" : "D"); end
        checks++; if ((bus.c_ack_o ? bus.c_rdata_o : bus.d_rdata_o) !== exp_q[0]) begin errors++; $display("FAIL rmid_data #%0d: got %h expected %h", order, bus.c_ack_o ? bus.c_rdata_o : bus.d_rdata_o, exp_q[0]); end
        void'(exp_q.pop_front());
        if (bus.c_ack_o) bus.c_req_i = 1'b0;
        else             bus.d_req_i = 1'b0;
        order++;
      end
    end
    checks++; if (order != 2) begin errors++; $display("FAIL rmid_timeout: got %0d acks expected 2", order); end
    bus.c_req_i = 1'b0; bus.d_req_i = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp;
    @(negedge clk);
    bus1.d_req_i = 1'b1; bus1.d_we_i = 1'b0; bus1.d_addr_i = 32'h0;
    exp_q.push_back(mem_val(32'h0));
    exp_q.push_back(mem_val(32'h4));
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      checks++; if (bus1.m_read_o !== 1'b1 || bus1.d_ack_o !== 1'b0) begin errors++; $display("FAIL b2b_strobe #%0d: got rd%b ack%b expected 1 0", n, bus1.m_read_o, bus1.d_ack_o); end
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++; if (bus1.d_ack_o !== 1'b1) begin errors++; $display("FAIL b2b_ack #%0d: got %b expected 1", n, bus1.d_ack_o); end
      checks++; if (bus1.d_rdata_o !== exp) begin errors++; $display("FAIL b2b_data #%0d: got %h expected %h", n, bus1.d_rdata_o, exp); end
      if (n == 0) begin
        bus1.d_addr_i = 32'h4;
        @(negedge clk);
        checks++; if (bus1.d_ack_o !== 1'b0 || bus1.m_read_o !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: got ack%b rd%b expected 0 0", bus1.d_ack_o, bus1.m_read_o); end
      end
    end
    bus1.d_req_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_round_robin();
    test_start_gate();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data memory between two requesters: port C (CPU MEM stage) and port D (debug/loader port that preloads or inspects memory).
- Sits between the EX/MEM pipeline register and data memory.
- Sequences each access over a fixed memory latency and drives a pipeline stall while the CPU access is outstanding.
- Round-robin arbitration; one access in flight at a time.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- MEM_LATENCY, 2, cycles the memory strobe is held per access; legal range 1..15.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  arbitration enable; low blocks new grants.
- c_req_i  in  1  CPU request, level; held until c_ack_o.
- c_we_i  in  1  CPU write (1) / read (0).
- c_addr_i  in  ADDR_W  CPU address.
- c_wdata_i  in  DATA_W  CPU write data.
- c_rdata_o  out  DATA_W  CPU read data; valid while c_ack_o=1.
- c_ack_o  out  1  CPU completion, one-cycle pulse.
- stall_o  out  1  pipeline stall to PC, IF/ID, ID/EX and EX/MEM.
- d_req_i  in  1  debug request, level.
- d_we_i  in  1  debug write/read.
- d_addr_i  in  ADDR_W  debug address.
- d_wdata_i  in  DATA_W  debug write data.
- d_rdata_o  out  DATA_W  debug read data; valid while d_ack_o=1.
- d_ack_o  out  1  debug completion pulse.
- m_addr_o  out  ADDR_W  memory address.
- m_wdata_o  out  DATA_W  memory write data.
- m_read_o  out  1  memory read strobe.
- m_write_o  out  1  memory write strobe.
- m_rdata_i  in  DATA_W  memory read data; valid on the last strobe cycle.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - All outputs 0 except stall_o, which follows its combinational equation.
  - State goes to IDLE, latency counter to 0, last-grant pointer to D, so C wins the first tie.
- States:
  - IDLE: if start_i=1 and any request is asserted, latch the winner's we/addr/wdata and grant id, load counter = MEM_LATENCY-1, go to ACCESS. Otherwise stay.
  - ACCESS: drive m_addr_o and m_wdata_o from the latched values. Assert m_read_o or m_write_o according to the latched we. When counter=0, capture m_rdata_i into the granted port's rdata register and go to DONE; otherwise decrement.
  - DONE: pulse the granted port's ack for one cycle, with rdata valid. Update the last-grant pointer and return to IDLE.
- Latency: request sampled in IDLE at cycle 0 → strobe cycles 1..MEM_LATENCY → ack at cycle MEM_LATENCY+1. At least one IDLE cycle separates consecutive accesses.
- Arbitration:
  - Only one requester: it wins.
  - Both requesting: the one not granted last wins.
  - Grants are decided only in IDLE; no preemption.
- Strobes are never both high. Both are 0 outside ACCESS. Outside ACCESS, m_addr_o and m_wdata_o hold their last value.
- rdata registers hold their value until overwritten by the next read on that port. A write ack leaves rdata unchanged.
- stall_o = c_req_i & ~c_ack_o, combinational.
- Requester drops req mid-access (protocol violation): the access still completes and ack is still pulsed.
- start_i falls mid-access: the in-flight access completes; no new grant until start_i=1.
- Reset mid-access: strobes and ack drop immediately and the access is abandoned.

Optional Feature:
- Macro: DMEM_ARB_CPU_PRIO_EN.
- Defined: fixed priority; C always wins a tie, and the last-grant pointer is unused.
- Undefined: round-robin as above.

Test Plan:
- MEM_LATENCY=2, CPU read addr 0x10, memory returns 0xDEADBEEF → m_read_o high at cycles 1–2; c_ack_o=1 and c_rdata_o=0xDEADBEEF at cycle 3; stall_o=1 at cycles 0–2 and 0 at cycle 3.
- CPU write addr 0x20 data 0x12345678 → m_write_o=1 for 2 cycles with m_addr_o=0x20 and m_wdata_o=0x12345678; c_ack_o pulses once; m_read_o stays 0.
- Both requesting continuously from reset → grant order C,D,C,D; each ack 4 cycles apart; never two strobes high together. With DMEM_ARB_CPU_PRIO_EN defined: C every time, D starved.
- start_i=0 with both requests high for 10 cycles → no strobes, no acks, stall_o=1. Raise start_i → C is granted first.
- rst_i driven low at cycle 2 of a D read → d_ack_o, m_read_o and state clear the same cycle. After release, a pending C request is granted first.
- MEM_LATENCY=1 back-to-back D reads to 0x0 and 0x4 → each ack at cycle 2 after its IDLE sample; d_rdata_o updates per read.
